// File: rtl/ram_arbiter_32x4.sv
// rtl/ram_arbiter_32x4.sv - round-robin arbiter with bounded lock sharing one 32x4 synchronous RAM
module ram_arbiter_32x4 #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic              lock_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic              lock_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_A = 2'd1,
        S_OWN_B = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_b;
    logic              w_last_b_nxt;
    logic [3:0]        r_burst_cnt;
    logic [3:0]        w_burst_cnt_nxt;
    logic              r_rvalid_a;
    logic              r_rvalid_b;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic              w_hold_a;
    logic              w_hold_b;
    logic              w_gnt_a;
    logic              w_gnt_b;

    assign w_hold_a = (r_state == S_OWN_A) && req_a && lock_a && (r_burst_cnt < LP_MAX_BURST);
    assign w_hold_b = (r_state == S_OWN_B) && req_b && lock_b && (r_burst_cnt < LP_MAX_BURST);

    // Grants are forced low while reset is held so the RAM sees no access.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (reset_n) begin
            if (w_hold_a) begin
                w_gnt_a = 1'b1;
            end else if (w_hold_b) begin
                w_gnt_b = 1'b1;
            end else if (req_a && req_b) begin
                w_gnt_a = r_last_b;
                w_gnt_b = !r_last_b;
            end else begin
                w_gnt_a = req_a;
                w_gnt_b = req_b;
            end
        end
    end

    always_comb begin
        w_state_nxt     = S_IDLE;
        w_last_b_nxt    = r_last_b;
        w_burst_cnt_nxt = 4'd0;
        if (w_gnt_a) begin
            w_state_nxt     = S_OWN_A;
            w_last_b_nxt    = 1'b0;
            w_burst_cnt_nxt = w_hold_a ? r_burst_cnt + 4'd1 : 4'd1;
        end else if (w_gnt_b) begin
            w_state_nxt     = S_OWN_B;
            w_last_b_nxt    = 1'b1;
            w_burst_cnt_nxt = w_hold_b ? r_burst_cnt + 4'd1 : 4'd1;
        end
    end

    always_comb begin
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (w_gnt_a) begin
            ram_wen  = we_a;
            ram_addr = addr_a;
            ram_din  = wdata_a;
        end else if (w_gnt_b) begin
            ram_wen  = we_b;
            ram_addr = addr_b;
            ram_din  = wdata_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last_b    <= 1'b1;
            r_burst_cnt <= 4'd0;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_b    <= w_last_b_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rvalid_a  <= w_gnt_a && !we_a;
            r_rvalid_b  <= w_gnt_b && !we_b;
            if (r_rvalid_a) begin
                r_rdata_a <= ram_dout;
            end
            if (r_rvalid_b) begin
                r_rdata_b <= ram_dout;
            end
        end
    end

    // RAM output is only meaningful in the valid cycle; otherwise show the last captured word.
    assign gnt_a    = w_gnt_a;
    assign gnt_b    = w_gnt_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata_a  = r_rvalid_a ? ram_dout : r_rdata_a;
    assign rdata_b  = r_rvalid_b ? ram_dout : r_rdata_b;

endmodule

// File: tb/tb_ram_arbiter_32x4.sv
// tb/tb_ram_arbiter_32x4.sv - directed self-checking bench for ram_arbiter_32x4
module tb_ram_arbiter_32x4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_a, we_a, lock_a;
    logic [4:0] addr_a;
    logic [3:0] wdata_a;
    logic       gnt_a, rvalid_a;
    logic [3:0] rdata_a;
    logic       req_b, we_b, lock_b;
    logic [4:0] addr_b;
    logic [3:0] wdata_b;
    logic       gnt_b, rvalid_b;
    logic [3:0] rdata_b;
    logic       ram_wen;
    logic [4:0] ram_addr;
    logic [3:0] ram_din;
    logic [3:0] ram_dout;

    logic [3:0] mem [32];
    int         n_total = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter_32x4 #(.ADDR_W(5), .DATA_W(4), .MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Synchronous RAM with registered read, preloaded with a known pattern.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 4'(i) ^ 4'hA;
        ram_dout = 4'h0;
    end

    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_wen) mem[ram_addr] <= ram_din;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock, input logic [4:0] addr, input logic [3:0] wd);
        req_a = req; we_a = we; lock_a = lock; addr_a = addr; wdata_a = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock, input logic [4:0] addr, input logic [3:0] wd);
        req_b = req; we_b = we; lock_b = lock; addr_b = addr; wdata_b = wd;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        set_a(1'b0, 1'b0, 1'b0, 5'h00, 4'h0);
        set_b(1'b0, 1'b0, 1'b0, 5'h00, 4'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        set_a(1'b1, 1'b1, 1'b0, 5'h08, 4'h5);
        set_b(1'b1, 1'b0, 1'b0, 5'h02, 4'h0);

        // Reset: requests present but nothing granted.
        mid();
        check_val("rst_gnt_a", gnt_a, 0);
        check_val("rst_gnt_b", gnt_b, 0);
        check_val("rst_ram_wen", ram_wen, 0);
        check_val("rst_ram_addr", ram_addr, 0);
        check_val("rst_rvalid_a", rvalid_a, 0);
        check_val("rst_rdata_a", rdata_a, 0);
        check_val("rst_rdata_b", rdata_b, 0);
        tick();
        reset_n = 1'b1;

        // Test 1: write then read back.
        set_a(1'b1, 1'b1, 1'b0, 5'h08, 4'h5);
        set_b(1'b0, 1'b0, 1'b0, 5'h00, 4'h0);
        mid();
        check_val("t1_wr_gnt_a", gnt_a, 1);
        check_val("t1_wr_gnt_b", gnt_b, 0);
        check_val("t1_wr_wen", ram_wen, 1);
        check_val("t1_wr_addr", ram_addr, 5'h08);
        check_val("t1_wr_din", ram_din, 4'h5);
        tick();
        set_a(1'b1, 1'b0, 1'b0, 5'h08, 4'h0);
        mid();
        check_val("t1_rd_gnt_a", gnt_a, 1);
        check_val("t1_rd_wen", ram_wen, 0);
        check_val("t1_wr_no_rvalid", rvalid_a, 0);
        tick();
        idle_all();
        mid();
        check_val("t1_rvalid_a", rvalid_a, 1);
        check_val("t1_rdata_a", rdata_a, 4'h5);
        check_val("t1_idle_addr", ram_addr, 0);
        check_val("t1_idle_gnt_a", gnt_a, 0);
        tick();
        set_b(1'b1, 1'b1, 1'b0, 5'h02, 4'h3);
        mid();
        check_val("t1_b_wr_gnt", gnt_b, 1);
        check_val("t1_rvalid_a_drop", rvalid_a, 0);
        check_val("t1_rdata_a_hold", rdata_a, 4'h5);
        tick();
        idle_all();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;

        // Test 2: both read every cycle, strict alternation.
        set_a(1'b1, 1'b0, 1'b0, 5'h08, 4'h0);
        set_b(1'b1, 1'b0, 1'b0, 5'h02, 4'h0);
        mid();
        check_val("t2_c1_gnt_a", gnt_a, 1);
        check_val("t2_c1_gnt_b", gnt_b, 0);
        tick();
        mid();
        check_val("t2_c2_gnt_b", gnt_b, 1);
        check_val("t2_c2_gnt_a", gnt_a, 0);
        check_val("t2_c2_ram_addr", ram_addr, 5'h02);
        check_val("t2_c2_rvalid_a", rvalid_a, 1);
        check_val("t2_c2_rdata_a", rdata_a, 4'h5);
        tick();
        mid();
        check_val("t2_c3_gnt_a", gnt_a, 1);
        check_val("t2_c3_rvalid_b", rvalid_b, 1);
        check_val("t2_c3_rdata_b", rdata_b, 4'h3);
        check_val("t2_c3_rvalid_a", rvalid_a, 0);
        tick();
        mid();
        check_val("t2_c4_gnt_b", gnt_b, 1);
        check_val("t2_c4_rvalid_a", rvalid_a, 1);
        tick();
        idle_all();
        mid();
        check_val("t2_c5_rvalid_b", rvalid_b, 1);
        check_val("t2_c5_rdata_b", rdata_b, 4'h3);
        check_val("t2_c5_no_gnt", {gnt_a, gnt_b}, 0);
        tick();

        // Test 3: locked A with B waiting, burst limited to 4.
        set_a(1'b1, 1'b0, 1'b1, 5'h08, 4'h0);
        set_b(1'b1, 1'b0, 1'b0, 5'h02, 4'h0);
        for (int i = 0; i < 4; i++) begin
            mid();
            check_val($sformatf("t3_lock_gnt_a_%0d", i), gnt_a, 1);
            check_val($sformatf("t3_lock_gnt_b_%0d", i), gnt_b, 0);
            if (i > 0) check_val($sformatf("t3_rvalid_a_%0d", i), rvalid_a, 1);
            tick();
        end
        mid();
        check_val("t3_limit_gnt_b", gnt_b, 1);
        check_val("t3_limit_gnt_a", gnt_a, 0);
        check_val("t3_limit_rdata_a", rdata_a, 4'h5);
        tick();
        mid();
        check_val("t3_rr_gnt_a", gnt_a, 1);
        check_val("t3_rr_rvalid_b", rvalid_b, 1);
        check_val("t3_rr_rdata_b", rdata_b, 4'h3);
        tick();
        idle_all();
        tick();

        // Test 4: lock dropped in cycle 2 hands over to B.
        set_a(1'b1, 1'b0, 1'b1, 5'h08, 4'h0);
        mid();
        check_val("t4_c1_gnt_a", gnt_a, 1);
        tick();
        set_a(1'b1, 1'b0, 1'b0, 5'h08, 4'h0);
        set_b(1'b1, 1'b0, 1'b0, 5'h02, 4'h0);
        mid();
        check_val("t4_c2_gnt_b", gnt_b, 1);
        check_val("t4_c2_gnt_a", gnt_a, 0);
        tick();
        set_b(1'b0, 1'b0, 1'b0, 5'h00, 4'h0);
        mid();
        check_val("t4_c3_gnt_a", gnt_a, 1);
        tick();
        idle_all();
        tick();

        // Test 5: top address write/read, then address 0.
        set_a(1'b1, 1'b1, 1'b0, 5'h1F, 4'hF);
        mid();
        check_val("t5_wr_addr", ram_addr, 5'h1F);
        check_val("t5_wr_din", ram_din, 4'hF);
        tick();
        set_a(1'b1, 1'b0, 1'b0, 5'h1F, 4'h0);
        mid();
        check_val("t5_rd_gnt_a", gnt_a, 1);
        tick();
        set_a(1'b1, 1'b0, 1'b0, 5'h00, 4'h0);
        mid();
        check_val("t5_rvalid_a", rvalid_a, 1);
        check_val("t5_rdata_1f", rdata_a, 4'hF);
        check_val("t5_addr0", ram_addr, 5'h00);
        tick();
        idle_all();
        mid();
        check_val("t5_rdata_00", rdata_a, 4'hA);
        tick();

        // Test 6: async reset in the cycle after a granted read.
        set_a(1'b1, 1'b0, 1'b0, 5'h08, 4'h0);
        mid();
        check_val("t6_gnt_a", gnt_a, 1);
        tick();
        set_a(1'b1, 1'b0, 1'b0, 5'h08, 4'h0);
        set_b(1'b1, 1'b0, 1'b0, 5'h02, 4'h0);
        check_val("t6_pre_rvalid_a", rvalid_a, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_rvalid_a", rvalid_a, 0);
        check_val("t6_rst_rdata_a", rdata_a, 0);
        check_val("t6_rst_gnt", {gnt_a, gnt_b}, 0);
        check_val("t6_rst_wen", ram_wen, 0);
        tick();
        #2;
        reset_n = 1'b1;
        mid();
        check_val("t6_post_gnt_a", gnt_a, 1);
        check_val("t6_post_gnt_b", gnt_b, 0);
        check_val("t6_post_rvalid_a", rvalid_a, 0);
        tick();
        idle_all();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_32x4.md
Name: ram_arbiter_32x4

Overview:
- Two-requester arbiter and sequencer sharing a single 32x4 synchronous RAM (5-bit address, 4-bit data, one write-enable, registered read data).
- Sits between the RAM and two clients, such as a switch-driven write/read port and an automatic address scanner feeding the hex display.
- Arbitration is round-robin, with an optional bounded lock for back-to-back bursts.
- Each accepted command goes to the RAM in the cycle it is granted. Read data returns to the granted client one cycle later with a valid strobe.

Parameters:
- ADDR_W, 5, RAM address width (32 words).
- DATA_W, 4, RAM data width.
- MAX_BURST, 4, maximum consecutive grants to one locked requester (1..15).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A command request.
- we_a  input  1  A: 1 = write, 0 = read.
- lock_a  input  1  A requests to keep ownership on following cycles.
- addr_a  input  ADDR_W  A address.
- wdata_a  input  DATA_W  A write data.
- gnt_a  output  1  A command accepted this cycle (combinational).
- rvalid_a  output  1  A read data valid (registered).
- rdata_a  output  DATA_W  A read data.
- req_b, we_b, lock_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as the A signals, for requester B.
- ram_wen  output  1  to RAM write enable.
- ram_addr  output  ADDR_W  to RAM address.
- ram_din  output  DATA_W  to RAM write data.
- ram_dout  input  DATA_W  from RAM; registered, valid the cycle after the address is presented.

Behaviour:
- State machine: owner state in {IDLE, OWN_A, OWN_B}, plus a last_grant bit and a burst_cnt counter (4 bits).
- Reset (async, reset_n = 0):
  - state = IDLE, last_grant = B (so A wins the first tie), burst_cnt = 0.
  - rvalid_a = rvalid_b = 0, rdata_a = rdata_b = 0.
  - All gnt and ram_* outputs are 0 while reset is asserted, regardless of req.
- Grant decision (combinational, each cycle):
  1. Lock hold: if state = OWN_X, req_X = 1, lock_X = 1 and burst_cnt < MAX_BURST, grant X. The other requester waits.
  2. Otherwise, only one req high: grant that requester.
  3. Otherwise, both req high: grant the requester that is not last_grant.
  4. No req: no grant.
- At most one gnt is high per cycle.
- Next state:
  - Grant to X: state becomes OWN_X and last_grant becomes X.
    - burst_cnt becomes burst_cnt + 1 if X was already the owner under lock hold; otherwise it becomes 1.
  - No grant: state becomes IDLE and burst_cnt becomes 0.
- Lock release:
  - Owner deasserting lock or req releases ownership immediately in that cycle's decision.
  - The counter saturates by rule: once burst_cnt = MAX_BURST, the lock hold is refused and normal round-robin applies.
  - Burst limit example: with MAX_BURST = 4 and B also requesting, a locked A gets exactly 4 consecutive grants, then B is granted.
- RAM drive (combinational):
  - When X is granted: ram_addr = addr_X, ram_din = wdata_X, ram_wen = we_X.
  - When nothing is granted: ram_wen = 0, ram_addr = 0, ram_din = 0.
- Read return:
  - rvalid_X is registered: it is high in cycle t+1 if gnt_X and !we_X were true in cycle t.
  - rdata_X = ram_dout while rvalid_X = 1; it holds its last value otherwise.
  - Read latency is exactly 1 cycle from grant.
  - A write grant never produces rvalid.
- Client handshake:
  - The client holds req, we, addr and wdata stable until it sees gnt high in the same cycle.
  - The command is consumed at the posedge ending that cycle.
  - The client deasserts req, or presents its next command, after that edge.
- Simultaneous events:
  - A read following a write to the same address in the next cycle returns the new data (the RAM writes at the edge; the read address is presented next cycle).
  - A and B targeting the same address in one cycle: only the granted requester's access occurs; the loser retries.
- Reset mid-operation:
  - Clears any pending rvalid and the lock immediately.
  - A read granted in the cycle reset asserts returns nothing.

Test Plan:
1. Reset, then A writes 0x5 to addr 0x08 (we_a = 1, req_a = 1) → gnt_a = 1 same cycle with ram_wen = 1, ram_addr = 0x08, ram_din = 0x5. Next cycle A reads 0x08 → one cycle later rvalid_a = 1, rdata_a = 0x5.
2. Both request reads every cycle from reset (A: addr 0x08, B: addr 0x02 holding 0x3) → grants alternate A, B, A, B. rvalid_a/rdata_a = 0x5 and rvalid_b/rdata_b = 0x3 each appear one cycle after the matching grant.
3. A locked (lock_a = 1) reading continuously, B requesting, MAX_BURST = 4 → gnt_a for exactly 4 cycles, then gnt_b, then round-robin. burst_cnt never exceeds 4.
4. A locked, then lock_a drops in cycle 2 while B requests → gnt_b in cycle 2. No extra A grant.
5. A write to 0x1F (value 0xF) then A read of 0x1F back-to-back → rdata_a = 0xF. Then address 0x00 read returns the reset-independent RAM content with no address wrap errors.
6. reset_n pulsed low asynchronously between clock edges, in the cycle immediately after a granted read → rvalid_a = 0 immediately and gnt_* = 0 during reset. After release, the first tie goes to A.
